// File: rtl/gate_sweep_driver_if.sv
// gate_sweep_driver_if
//   Bundles the sweep control/status signals and the gate-under-test
//   connections used by gate_sweep_driver.
//   start      : single-cycle sweep request (into the driver)
//   f          : output of the gate under test (into the driver)
//   a, b       : gate inputs (from the driver)
//   busy       : sweep in progress
//   done       : sweep complete, held until the next accepted start
//   pass       : done with no mismatching vector
//   err_count  : number of mismatching vectors, 0..4
//   fail_vec   : bit i set when vector {a,b}=i mismatched
//   Modport slave is the driver side; modport master is the system side.
interface gate_sweep_driver_if;
  logic       start;
  logic       f;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  modport slave (
    input  start,
    input  f,
    output a,
    output b,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_vec
  );

  modport master (
    output start,
    output f,
    input  a,
    input  b,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_vec
  );
endinterface

// File: rtl/gate_sweep_driver.sv
// gate_sweep_driver
//   Drives a two-input gate through {a,b} = 00, 01, 10, 11, holding each
//   vector for HOLD_CYCLES clocks, samples the gate output at the end of
//   each hold and checks it against the EXPECT truth table.
//   Parameters:
//     HOLD_CYCLES : clocks per vector, legal range 2..255
//     EXPECT      : expected gate output, bit index = {a,b} (default AND)
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : gate_sweep_driver_if.slave (start, f in; a, b, busy, done,
//             pass, err_count, fail_vec out)
module gate_sweep_driver #(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [3:0] EXPECT      = 4'b1000
) (
  input  logic                clk,
  input  logic                rst_n,
  gate_sweep_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [1:0] vec;
  logic [7:0] hcnt;
  logic       a_q;
  logic       b_q;
  logic       vld_p1;
  logic       miss_p1;
  logic [1:0] vec_p1;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic       accept;
  logic       hold_end;

  // A start is honoured only outside RUN; while busy it is dropped.
  assign accept   = (state != RUN) && bus.start;
  assign hold_end = (state == RUN) && (hcnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The sweep ends one clock after the last sample, when the final
  // compare result has been folded into the counters.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (vld_p1 && (vec_p1 == 2'd3)) state_next = DONE;
      DONE:    if (bus.start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: vector index and hold counter. The start edge itself is the
  // first hold clock of vector 0, so the counter is loaded with 1 there;
  // every vector then gets exactly HOLD_CYCLES clocks on the gate inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec    <= 2'd0;
      hcnt   <= 8'd0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= hold_end;
      if (accept) begin
        vec  <= 2'd0;
        hcnt <= 8'd1;
      end else if (hold_end) begin
        vec  <= vec + 2'd1;
        hcnt <= 8'd0;
      end else if (state == RUN) begin
        hcnt <= hcnt + 8'd1;
      end
    end
  end

  // Gate inputs follow the index one clock late, so a new vector appears
  // on the edge after the previous one was sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else if ((state == RUN) && (state_next == RUN)) begin
      {a_q, b_q} <= vec;
    end else begin
      {a_q, b_q} <= 2'b00;
    end
  end

  // Stage p1: sampled compare result for the vector whose hold just ended.
  always_ff @(posedge clk) begin
    if (hold_end) begin
      miss_p1 <= (bus.f != EXPECT[vec]);
      vec_p1  <= vec;
    end
  end

  // Stage p2: accumulate results; cleared on every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else if (accept) begin
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else if (vld_p1 && miss_p1) begin
      err_count        <= err_count + 3'd1;
      fail_vec[vec_p1] <= 1'b1;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.pass      = (state == DONE) && (err_count == 3'd0);
  assign bus.err_count = err_count;
  assign bus.fail_vec  = fail_vec;

endmodule

// File: tb/tb_gate_sweep_driver.sv
// tb_gate_sweep_driver
//   Bench for gate_sweep_driver: one instance with default parameters and
//   one with HOLD_CYCLES=2. Each gate under test is a programmable truth
//   table; expectations come from an arithmetic model of the sweep
//   timeline (vector = cycle / HOLD, results land one clock after each
//   hold ends, done at 4*HOLD).
module tb_gate_sweep_driver;

  logic clk;
  logic rst_n;
  logic [3:0] tt10;
  logic [3:0] tt2;
  int vectors;
  int miscompares;

  localparam logic [3:0] EXP_TT = 4'b1000;

  gate_sweep_driver_if if10();
  gate_sweep_driver_if if2();

  assign if10.f = tt10[{if10.a, if10.b}];
  assign if2.f  = tt2[{if2.a, if2.b}];

  gate_sweep_driver u10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if10.slave)
  );

  gate_sweep_driver #(.HOLD_CYCLES(2), .EXPECT(4'b1000)) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) if10.start = v;
    else          if2.start  = v;
  endtask

  task automatic get_out(input int sel, output logic [1:0] ab, output logic bsy,
                         output logic dn, output logic ps, output logic [2:0] er,
                         output logic [3:0] fv);
    if (sel == 0) begin
      ab = {if10.a, if10.b}; bsy = if10.busy; dn = if10.done;
      ps = if10.pass; er = if10.err_count; fv = if10.fail_vec;
    end else begin
      ab = {if2.a, if2.b}; bsy = if2.busy; dn = if2.done;
      ps = if2.pass; er = if2.err_count; fv = if2.fail_vec;
    end
  endtask

  task automatic chk_idle(input int sel, input string tag);
    logic [1:0] ab; logic bsy, dn, ps; logic [2:0] er; logic [3:0] fv;
    get_out(sel, ab, bsy, dn, ps, er, fv);
    chk({tag, ".ab"},   32'(ab),  32'd0);
    chk({tag, ".busy"}, 32'(bsy), 32'd0);
    chk({tag, ".done"}, 32'(dn),  32'd0);
    chk({tag, ".pass"}, 32'(ps),  32'd0);
    chk({tag, ".err"},  32'(er),  32'd0);
    chk({tag, ".fail"}, 32'(fv),  32'd0);
  endtask

  // Runs one sweep starting at posedge+#1. e1/e2: edge numbers (relative to
  // the start edge 0) on which an extra start is presented; rst_at: cycle
  // after which reset is asserted (-1 for none).
  task automatic run_sweep(input int sel, input logic [3:0] tbl, input int e1,
                           input int e2, input int rst_at);
    int h;
    logic [3:0] diff;
    logic [1:0] ab; logic bsy, dn, ps; logic [2:0] er; logic [3:0] fv;
    logic [1:0] x_ab; logic [2:0] x_er; logic [3:0] x_fv;
    h = (sel == 0) ? 10 : 2;
    if (sel == 0) tt10 = tbl; else tt2 = tbl;
    diff = tbl ^ EXP_TT;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    for (int c = 0; c <= 4 * h; c++) begin
      set_start(sel, ((c + 1) == e1) || ((c + 1) == e2));
      x_ab = (c < 4 * h) ? 2'(c / h) : 2'd0;
      x_er = 3'd0;
      x_fv = 4'd0;
      for (int k = 0; k < 4; k++) begin
        if (((k + 1) * h <= c) && diff[k]) begin
          x_er = x_er + 3'd1;
          x_fv[k] = 1'b1;
        end
      end
      get_out(sel, ab, bsy, dn, ps, er, fv);
      chk("ab",   32'(ab),  32'(x_ab));
      chk("busy", 32'(bsy), 32'(c < 4 * h));
      chk("done", 32'(dn),  32'(c >= 4 * h));
      chk("pass", 32'(ps),  32'((c >= 4 * h) && (x_er == 3'd0)));
      chk("err",  32'(er),  32'(x_er));
      chk("fail", 32'(fv),  32'(x_fv));
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        set_start(sel, 1'b0);
        chk_idle(sel, "rst_async");
        return;
      end
      if (c < 4 * h) begin
        @(posedge clk); #1;
      end
    end
    set_start(sel, 1'b0);
    @(posedge clk); #1;
    get_out(sel, ab, bsy, dn, ps, er, fv);
    chk("hold.done", 32'(dn),  32'd1);
    chk("hold.busy", 32'(bsy), 32'd0);
    chk("hold.ab",   32'(ab),  32'd0);
    chk("hold.err",  32'(er),  32'($countones(diff)));
    chk("hold.fail", 32'(fv),  32'(diff));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    if10.start  = 1'b0;
    if2.start   = 1'b0;
    tt10        = 4'b1000;
    tt2         = 4'b1000;

    repeat (3) @(posedge clk);
    #1;
    chk_idle(0, "reset10");
    chk_idle(1, "reset2");
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk_idle(0, "idle10");

    run_sweep(0, 4'b1000, -1, -1, -1);   // AND
    run_sweep(0, 4'b0111, -1, -1, -1);   // NAND
    run_sweep(0, 4'b0110, -1, -1, -1);   // XOR
    run_sweep(0, 4'b1000,  5, 20, -1);   // starts while busy
    run_sweep(0, 4'b0111, 40, -1, -1);   // start on the DONE-entry edge
    run_sweep(1, 4'b1000, -1, -1, -1);   // HOLD_CYCLES=2, AND
    run_sweep(1, 4'b0110,  3,  8, -1);

    // abort a failing sweep with reset
    run_sweep(0, 4'b0111, -1, -1, 17);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk_idle(0, "rst_hold");
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk_idle(0, "post_rst_idle");
    run_sweep(0, 4'b1000, -1, -1, -1);

    for (int r = 0; r < 8; r++) begin
      int sel;
      int h;
      int e1;
      int e2;
      logic [3:0] tbl;
      sel = int'($urandom_range(0, 1));
      h   = (sel == 0) ? 10 : 2;
      tbl = 4'($urandom);
      e1  = int'($urandom_range(1, 4 * h));
      e2  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4 * h)) : -1;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      run_sweep(sel, tbl, e1, e2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
